// File: rtl/ap_line_cached.sv
// BCD address pointer with a write-back, single-cell data cache in front of a synchronous RAM.
// Requests carry a BCD repeat count; the pointer and cell step once per clock until it is used up.
module ap_line_cached #(
  parameter int unsigned AP_DIGITS   = 6,
  parameter int unsigned DATA_DIGITS = 3,
  parameter int unsigned STEP_DIGITS = 2,
  parameter int unsigned DEPTH       = 30000
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     ApRequest,
  input  logic                     DataRequest,
  input  logic                     Dec,
  input  logic                     Flush,
  input  logic [4*STEP_DIGITS-1:0] Step,
  output logic                     Ready,
  output logic                     ApZero,
  output logic                     DataZero,
  output logic [4*AP_DIGITS-1:0]   Address,
  output logic [4*DATA_DIGITS-1:0] Data,
  output logic [4*AP_DIGITS-1:0]   MemAddr,
  output logic [4*DATA_DIGITS-1:0] MemWData,
  output logic                     MemWE,
  input  logic [4*DATA_DIGITS-1:0] MemRData
);

  localparam int unsigned AW = 4 * AP_DIGITS;
  localparam int unsigned DW = 4 * DATA_DIGITS;
  localparam int unsigned SW = 4 * STEP_DIGITS;
  localparam int unsigned RW = $clog2(10 ** STEP_DIGITS) + 1;

  function automatic logic [AW-1:0] to_bcd(input int unsigned v);
    logic [AW-1:0] r;
    int unsigned   t;
    r = '0;
    t = v;
    for (int i = 0; i < int'(AP_DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [AW-1:0] AddrMax = to_bcd(DEPTH - 1);

  // A count of zero still performs one step.
  function automatic logic [RW-1:0] step_count(input logic [SW-1:0] s);
    logic [RW-1:0] acc;
    acc = '0;
    for (int i = int'(STEP_DIGITS) - 1; i >= 0; i--) begin
      acc = acc * RW'(10) + RW'(s[4*i +: 4]);
    end
    if (acc == '0) acc = RW'(1);
    return acc;
  endfunction

  function automatic logic [AW-1:0] ap_next(input logic [AW-1:0] a, input logic dec);
    logic [AW-1:0] r;
    logic          carry;
    logic [3:0]    d;
    r     = a;
    carry = 1'b1;
    for (int i = 0; i < int'(AP_DIGITS); i++) begin
      d = a[4*i +: 4];
      if (carry) begin
        if (dec) begin
          carry = (d == 4'd0);
          d     = carry ? 4'd9 : d - 4'd1;
        end else begin
          carry = (d == 4'd9);
          d     = carry ? 4'd0 : d + 4'd1;
        end
      end
      r[4*i +: 4] = d;
    end
    if (!dec && a == AddrMax) r = '0;
    else if (dec && a == '0) r = AddrMax;
    return r;
  endfunction

  // Full decimal range, so the wrap falls out of the digit carry chain.
  function automatic logic [DW-1:0] data_next(input logic [DW-1:0] a, input logic dec);
    logic [DW-1:0] r;
    logic          carry;
    logic [3:0]    d;
    r     = a;
    carry = 1'b1;
    for (int i = 0; i < int'(DATA_DIGITS); i++) begin
      d = a[4*i +: 4];
      if (carry) begin
        if (dec) begin
          carry = (d == 4'd0);
          d     = carry ? 4'd9 : d - 4'd1;
        end else begin
          carry = (d == 4'd9);
          d     = carry ? 4'd0 : d + 4'd1;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLoadWait,
    StStore,
    StCountAp,
    StCountData,
    StFlush
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] cache_q, cache_d;
  logic          valid_q, valid_d;
  logic          dirty_q, dirty_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic          dec_q, dec_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cache_q <= '0;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cache_q <= cache_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cache_d = cache_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    case (state_q)
      StIdle: begin
        // Data wins over pointer moves, which win over flush; losers are dropped.
        if (DataRequest) begin
          cnt_d   = step_count(Step);
          dec_d   = Dec;
          state_d = valid_q ? StCountData : StLoad;
        end else if (ApRequest) begin
          cnt_d = step_count(Step);
          dec_d = Dec;
          if (valid_q && dirty_q) begin
            state_d = StStore;
          end else begin
            valid_d = 1'b0;
            state_d = StCountAp;
          end
        end else if (Flush && valid_q && dirty_q) begin
          state_d = StFlush;
        end
      end
      StLoad: state_d = StLoadWait;
      StLoadWait: begin
        cache_d = MemRData;
        valid_d = 1'b1;
        state_d = StCountData;
      end
      StStore: begin
        valid_d = 1'b0;
        dirty_d = 1'b0;
        state_d = StCountAp;
      end
      StCountAp: begin
        addr_d = ap_next(addr_q, dec_q);
        cnt_d  = cnt_q - RW'(1);
        if (cnt_q == RW'(1)) state_d = StIdle;
      end
      StCountData: begin
        cache_d = data_next(cache_q, dec_q);
        dirty_d = 1'b1;
        cnt_d   = cnt_q - RW'(1);
        if (cnt_q == RW'(1)) state_d = StIdle;
      end
      StFlush: begin
        dirty_d = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Ready    = (state_q == StIdle) && !ApRequest && !DataRequest && !Flush;
    Address  = addr_q;
    MemAddr  = addr_q;
    ApZero   = (addr_q == '0);
    Data     = valid_q ? cache_q : MemRData;
    DataZero = (Data == '0);
    MemWData = cache_q;
    MemWE    = (state_q == StStore) || (state_q == StFlush);
  end

endmodule

// File: tb/tb_ap_line_cached.sv
// Randomised bench for ap_line_cached: a request-level model predicts each cycle's outputs,
// a negedge compare process checks them, and a few literal checks pin the model.
module tb_ap_line_cached;

  localparam int DEPTH = 30000;

  logic        Clk = 1'b0;
  logic        Rst, ApRequest, DataRequest, Dec, Flush;
  logic [7:0]  Step;
  logic        Ready, ApZero, DataZero, MemWE;
  logic [23:0] Address, MemAddr;
  logic [11:0] Data, MemWData, MemRData;

  always #5 Clk = ~Clk;

  ap_line_cached #(
    .AP_DIGITS  (6),
    .DATA_DIGITS(3),
    .STEP_DIGITS(2),
    .DEPTH      (DEPTH)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .ApRequest  (ApRequest),
    .DataRequest(DataRequest),
    .Dec        (Dec),
    .Flush      (Flush),
    .Step       (Step),
    .Ready      (Ready),
    .ApZero     (ApZero),
    .DataZero   (DataZero),
    .Address    (Address),
    .Data       (Data),
    .MemAddr    (MemAddr),
    .MemWData   (MemWData),
    .MemWE      (MemWE),
    .MemRData   (MemRData)
  );

  function automatic int from_bcd(input logic [23:0] b);
    int r;
    r = 0;
    for (int i = 5; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [11:0] to_bcd_d(input int v);
    logic [11:0] r;
    int          t;
    t = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int init_val(input int a);
    if (a == 5) return 42;
    if (a == DEPTH - 1) return 0;
    return (a * 37 + 11) % 1000;
  endfunction

  function automatic int wrapm(input int x, input int m);
    return ((x % m) + m) % m;
  endfunction

  // Synchronous RAM, read-first, one-cycle latency.
  logic [11:0] ram [0:DEPTH-1];
  bit          ram_ready = 1'b0;
  always @(posedge Clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= to_bcd_d(init_val(i));
      ram_ready <= 1'b1;
    end else if (from_bcd(MemAddr) < DEPTH) begin
      if (MemWE) ram[from_bcd(MemAddr)] <= MemWData;
      MemRData <= ram[from_bcd(MemAddr)];
    end
  end

  // Request-level model.
  int m_addr, m_cache;
  bit m_valid, m_dirty;
  int mmem [DEPTH];

  int e_addr, e_data, e_wdata;
  bit e_ready, e_we, e_chk_data, chk_en;

  int          total = 0, bad = 0, we_count = 0;
  logic [23:0] last_waddr;
  logic [11:0] last_wdata;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge Clk);
      if (chk_en) begin
        check("addr", from_bcd(Address), e_addr);
        check("mem_addr", from_bcd(MemAddr), e_addr);
        check("ap_zero", int'(ApZero), int'(e_addr == 0));
        check("ready", int'(Ready), int'(e_ready));
        check("mem_we", int'(MemWE), int'(e_we));
        if (e_we) check("mem_wdata", from_bcd({12'd0, MemWData}), e_wdata);
        if (e_chk_data) begin
          check("data", from_bcd({12'd0, Data}), e_data);
          check("data_zero", int'(DataZero), int'(e_data == 0));
        end
        if (MemWE) begin
          we_count++;
          last_waddr = MemAddr;
          last_wdata = MemWData;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_idle(input bit full);
    e_addr     = m_addr;
    e_ready    = 1'b1;
    e_we       = 1'b0;
    e_chk_data = m_valid || full;
    e_data     = m_valid ? m_cache : mmem[m_addr];
  endtask

  // kind: 0 pointer move, 1 data change, 2 flush, 3 all three requests at once.
  task automatic run_op(input int kind, input bit dec, input int step, input int abort_at);
    int n, pre, len, v, sgn;
    bit wb, is_data;
    n       = (step == 0) ? 1 : step;
    sgn     = dec ? -1 : 1;
    is_data = (kind == 1) || (kind == 3);
    wb      = m_valid && m_dirty;
    v       = m_valid ? m_cache : mmem[m_addr];
    Step        = 8'(((step / 10) * 16) + (step % 10));
    Dec         = dec;
    ApRequest   = (kind == 0) || (kind == 3);
    DataRequest = is_data;
    Flush       = (kind == 2) || (kind == 3);
    set_idle(1'b1);
    e_ready = 1'b0;
    if (is_data) begin
      pre = m_valid ? 0 : 2;
      len = n + pre;
    end else if (kind == 0) begin
      pre = wb ? 1 : 0;
      len = n + pre;
    end else begin
      pre = 0;
      len = wb ? 1 : 0;
    end
    tick();
    ApRequest   = 1'b0;
    DataRequest = 1'b0;
    Flush       = 1'b0;
    for (int c = 0; c < len; c++) begin
      e_ready    = 1'b0;
      e_we       = 1'b0;
      e_chk_data = 1'b0;
      e_addr     = m_addr;
      if (is_data) begin
        if (c >= pre) begin
          e_chk_data = 1'b1;
          e_data     = wrapm(v + sgn * (c - pre), 1000);
        end
      end else begin
        if (kind == 0 && c > pre) e_addr = wrapm(m_addr + sgn * (c - pre), DEPTH);
        if (c == 0 && wb) begin
          e_we       = 1'b1;
          e_wdata    = m_cache;
          e_chk_data = 1'b1;
          e_data     = m_cache;
        end
      end
      if (c == abort_at) Rst = 1'b1;
      tick();
      if (c == abort_at) begin
        Rst = 1'b0;
        if (wb && !is_data) mmem[m_addr] = m_cache;
        m_addr  = 0;
        m_cache = 0;
        m_valid = 1'b0;
        m_dirty = 1'b0;
        set_idle(1'b0);
        tick();
        set_idle(1'b1);
        return;
      end
    end
    if (is_data) begin
      m_cache = wrapm(v + sgn * n, 1000);
      m_valid = 1'b1;
      m_dirty = 1'b1;
    end else if (kind == 0) begin
      if (wb) mmem[m_addr] = m_cache;
      m_addr  = wrapm(m_addr + sgn * n, DEPTH);
      m_valid = 1'b0;
      m_dirty = 1'b0;
    end else if (wb) begin
      mmem[m_addr] = m_cache;
      m_dirty = 1'b0;
    end
    set_idle(1'b0);
    tick();
    set_idle(1'b1);
  endtask

  initial begin
    int we_before, r, step;
    chk_en      = 1'b0;
    Rst         = 1'b1;
    ApRequest   = 1'b0;
    DataRequest = 1'b0;
    Dec         = 1'b0;
    Flush       = 1'b0;
    Step        = 8'h00;
    for (int i = 0; i < DEPTH; i++) mmem[i] = init_val(i);
    m_addr  = 0;
    m_cache = 0;
    m_valid = 1'b0;
    m_dirty = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    set_idle(1'b0);
    chk_en = 1'b1;
    check("rst_addr", int'(Address), 0);
    check("rst_ready", int'(Ready), 1);
    check("rst_we", int'(MemWE), 0);
    tick();
    set_idle(1'b1);

    run_op(0, 1'b0, 5, -1);
    check("lit_addr_5", int'(Address), 'h000005);
    check("lit_no_we", we_count, 0);

    run_op(1, 1'b0, 3, -1);
    check("lit_data_045", int'(Data), 'h045);

    run_op(0, 1'b1, 1, -1);
    check("lit_wb_count", we_count, 1);
    check("lit_wb_addr", int'(last_waddr), 'h000005);
    check("lit_wb_data", int'(last_wdata), 'h045);
    check("lit_addr_4", int'(Address), 'h000004);

    run_op(0, 1'b1, 4, -1);
    check("lit_ap_zero", int'(ApZero), 1);
    run_op(0, 1'b1, 0, -1);
    check("lit_addr_wrap", int'(Address), 'h029999);
    check("lit_ap_zero_fall", int'(ApZero), 0);

    run_op(1, 1'b0, 1, -1);
    run_op(1, 1'b1, 1, -1);
    check("lit_data_zero", int'(DataZero), 1);
    run_op(1, 1'b1, 1, -1);
    check("lit_data_999", int'(Data), 'h999);
    check("lit_data_zero_fall", int'(DataZero), 0);

    run_op(3, 1'b1, 1, -1);
    check("lit_both_addr", int'(Address), 'h029999);
    check("lit_both_data", int'(Data), 'h998);

    we_before = we_count;
    run_op(2, 1'b0, 0, -1);
    check("lit_flush_we", we_count, we_before + 1);
    check("lit_flush_data", int'(last_wdata), 'h998);
    run_op(2, 1'b0, 0, -1);
    check("lit_flush_clean", we_count, we_before + 1);

    for (int k = 0; k < 250; k++) begin
      r    = int'($urandom_range(0, 9));
      step = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 99));
      if (r < 4) run_op(0, 1'($urandom_range(0, 1)), step, -1);
      else if (r < 8) run_op(1, 1'($urandom_range(0, 1)), step, -1);
      else if (r == 8) run_op(2, 1'b0, step, -1);
      else run_op(3, 1'($urandom_range(0, 1)), step, -1);
    end

    run_op(2, 1'b0, 0, -1);
    we_before = we_count;
    run_op(0, 1'b0, 20, 5);
    check("lit_abort_addr", int'(Address), 0);
    check("lit_abort_ready", int'(Ready), 1);
    check("lit_abort_we", we_count, we_before);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ap_line_cached.md
Name: ap_line_cached

Overview:
- Parametrised successor to the address-pointer/data line of the Brainfuck datapath.
- Holds a BCD address pointer and a write-back, single-cell data cache in front of an external synchronous data RAM.
- Adds multi-step counts per request (run-length +/-N), dirty tracking so only modified cells are written back, explicit flush, configurable address wrap depth, and parametrised digit counts.

Parameters:
- AP_DIGITS, 6, number of BCD digits in the address pointer.
- DATA_DIGITS, 3, number of BCD digits in a data cell.
- STEP_DIGITS, 2, number of BCD digits in the Step input.
- DEPTH, 30000, number of RAM cells. Address wraps modulo DEPTH; DEPTH must be at most 10^AP_DIGITS.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous reset, active-high.
- ApRequest  in  1  move the address pointer by Step.
- DataRequest  in  1  change the current cell by Step.
- Dec  in  1  direction: 1 = decrement, 0 = increment. Sampled on accept.
- Flush  in  1  write back the cached cell if it is dirty.
- Step  in  4*STEP_DIGITS  BCD repeat count. A value of 0 is treated as 1.
- Ready  out  1  block is idle and no request is pending.
- ApZero  out  1  Address == 0.
- DataZero  out  1  Data == 0.
- Address  out  4*AP_DIGITS  current pointer (BCD).
- Data  out  4*DATA_DIGITS  current cell value (BCD).
- MemAddr  out  4*AP_DIGITS  RAM address; always equal to Address.
- MemWData  out  4*DATA_DIGITS  RAM write data; always equal to the cache register.
- MemWE  out  1  one-cycle RAM write strobe.
- MemRData  in  4*DATA_DIGITS  RAM read data. One-cycle latency: address registered at an edge, data valid until the next edge.

Behaviour:
- Reset (Rst high at an edge):
  - Address=0, cache=0, Valid=0, Dirty=0, MemWE=0, state=IDLE.
  - Reset mid-operation abandons the operation; no write-back occurs.
- Outputs:
  - Ready = (state==IDLE) & ~ApRequest & ~DataRequest & ~Flush.
  - Data = Valid ? cache : MemRData.
- State set: IDLE, LOAD, LOAD_WAIT, STORE, COUNT_AP, COUNT_DATA, FLUSH_ST.
- Acceptance:
  - Requests are accepted only in IDLE; requests in any other state are ignored, not queued.
  - On accept, Step is latched into a remaining-count register R (0 becomes 1) and Dec is latched.
  - Priority when several requests are high in IDLE: DataRequest > ApRequest > Flush. Lower-priority requests are dropped, and the requester must hold or re-issue them.
- DataRequest, Valid=0: IDLE -> LOAD -> LOAD_WAIT. At the LOAD_WAIT edge, cache <= MemRData and Valid <= 1, then -> COUNT_DATA.
- DataRequest, Valid=1: IDLE -> COUNT_DATA directly.
- COUNT_DATA:
  - One unit per edge: cache +/- 1, modulo 10^DATA_DIGITS (999 +1 -> 000, 000 -1 -> 999). Dirty <= 1. R decrements.
  - The edge at which R reaches 0 returns to IDLE.
- ApRequest, Valid & Dirty: IDLE -> STORE. STORE asserts MemWE for exactly one cycle with the old address, then Valid=0, Dirty=0, -> COUNT_AP.
- ApRequest, otherwise: Valid <= 0, IDLE -> COUNT_AP.
- COUNT_AP:
  - One unit per edge: Address +/- 1 with decimal carry; DEPTH-1 +1 -> 0 and 0 -1 -> DEPTH-1. R decrements.
  - Ends at IDLE as for COUNT_DATA.
- Flush:
  - Valid & Dirty: IDLE -> FLUSH_ST. MemWE is high for one cycle, Dirty <= 0, Valid stays 1, -> IDLE.
  - Otherwise: no-op. Ready stays low only while Flush is held.
- Latency in edges from the accept edge to IDLE:
  - Clean AP move: N.
  - Dirty AP move: N+1.
  - Cached data change: N.
  - Uncached data change: N+2.
  - Flush: 1.
- MemWE is never asserted outside STORE and FLUSH_ST.
- Combined moves do not double-count: Address changes exactly N times per accepted request.

Test Plan:
- Reset, then ApRequest with Dec=0, Step=05 -> Address steps 1,2,3,4,5 on consecutive edges; Ready returns 5 edges after accept; MemWE never asserted.
- RAM[5]=042; DataRequest with Dec=0, Step=03 -> LOAD, then Data=042, then 043, 044, 045; Ready returns 5 edges after accept; Dirty=1.
- Continue: ApRequest with Dec=1, Step=01 -> exactly one MemWE pulse with MemAddr=5 and MemWData=045; Address=4; Valid=0, so Data tracks RAM[4].
- Address=0; ApRequest with Dec=1, Step=00 (treated as 1) -> Address=DEPTH-1=29999, ApZero falls. A cached cell holding 000 with Dec=1, Step=1 -> Data=999, DataZero falls.
- ApRequest and DataRequest both high in IDLE -> only the data operation executes and Address is unchanged. Flush on a clean cell -> no MemWE.
- Rst asserted in the middle of a COUNT_AP with Step=20 -> next cycle Address=0, Valid=0, Ready=1, no MemWE.
